// File: rtl/summator_n_pkg.sv
// rtl/summator_n_pkg.sv - shared state type, segment glyph table and digit-count helper for summator_n
package summator_n_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // Active-low gfedcba glyphs, entry 15 (F) listed first
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int digits(input int width);
        return (width + 3) / 4;
    endfunction

endpackage

// File: rtl/summator_n_hex7seg.sv
// rtl/summator_n_hex7seg.sv - one hex nibble to seven active-low segments
module hex7seg
    import summator_n_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_GLYPHS[nibble];

endmodule

// File: rtl/summator_n_key.sv
// rtl/summator_n_key.sv - key synchroniser, optional debouncer (SUMMATOR_N_DEBOUNCE_EN) and press detector
module summator_n_key #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic       level_q;
    logic [1:0] fill;
    logic       armed;

    // fill tracks when sync2 carries a real post-reset sample; armed blocks
    // a press from a key that was already held when reset released
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level_q <= 1'b1;
            fill    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            sync1   <= key;
            sync2   <= sync1;
            level_q <= level;
            fill    <= {fill[0], 1'b1};
            if (fill[1] && sync2) begin
                armed <= 1'b1;
            end
        end
    end

`ifdef SUMMATOR_N_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] deb_cnt;
    logic          deb_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_level <= 1'b1;
            deb_cnt   <= '0;
        end else if (sync2 == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
            deb_level <= sync2;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign level = deb_level;
`else
    logic unused_deb;

    assign unused_deb = DEB_CYCLES[0];
    assign level      = sync2;
`endif

    assign press = armed & level_q & ~level;

endmodule

// File: rtl/summator_n.sv
// rtl/summator_n.sv - button-driven N-operand accumulator with hex display; SUMMATOR_N_DEBOUNCE_EN enables key debounce
module summator_n
    import summator_n_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_load,
    input  logic                        key_clr,
    input  logic [WIDTH-1:0]            sw,
    output logic [WIDTH-1:0]            sum,
    output logic [3:0]                  cnt,
    output logic                        done,
    output logic                        ovf,
    output logic [7*digits(WIDTH)-1:0]  hex
);

    localparam int         DIGITS    = digits(WIDTH);
    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

    logic           load_press;
    logic           clr_press;
    state_t         state;
    logic [WIDTH:0] add_full;
    logic [3:0]     cnt_inc;

    summator_n_key #(.DEB_CYCLES(DEB_CYCLES)) u_key_load (
        .clk   (clk),
        .rst   (rst),
        .key   (key_load),
        .press (load_press)
    );

    summator_n_key #(.DEB_CYCLES(DEB_CYCLES)) u_key_clr (
        .clk   (clk),
        .rst   (rst),
        .key   (key_clr),
        .press (clr_press)
    );

    assign add_full = {1'b0, sum} + {1'b0, sw};
    assign cnt_inc  = cnt + 4'd1;

    // Clear has priority over a same-cycle load; loads in FULL are dropped
    always_ff @(posedge clk) begin
        if (rst || clr_press) begin
            state <= S_IDLE;
            sum   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load_press && state != S_FULL) begin
            sum <= add_full[WIDTH-1:0];
            cnt <= cnt_inc;
            if (add_full[WIDTH]) begin
                ovf <= 1'b1;
            end
            if (cnt_inc == DEPTH_CNT) begin
                state <= S_FULL;
                done  <= 1'b1;
            end else begin
                state <= S_ACCUM;
            end
        end
    end

    logic [4*DIGITS-1:0] sum_pad;

    assign sum_pad = (4*DIGITS)'(sum);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        hex7seg u_seg (
            .nibble (sum_pad[4*i +: 4]),
            .seg    (hex[7*i +: 7])
        );
    end

endmodule

// File: tb/tb_summator_n.sv
// tb/tb_summator_n.sv - self-checking bench for summator_n against a behavioural accumulator model
module tb_summator_n;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int DEB   = 16;
`ifdef SUMMATOR_N_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_load = 1'b1;
    logic        key_clr = 1'b1;
    logic [7:0]  sw = 8'h00;
    logic [7:0]  sum;
    logic [3:0]  cnt;
    logic        done;
    logic        ovf;
    logic [13:0] hex;

    int   n_checks = 0;
    int   n_fail = 0;
    int   m_sum = 0;
    int   m_cnt = 0;
    logic m_ovf = 1'b0;

    summator_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_load (key_load),
        .key_clr  (key_clr),
        .sw       (sw),
        .sum      (sum),
        .cnt      (cnt),
        .done     (done),
        .ovf      (ovf),
        .hex      (hex)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] exp_vec();
        logic [7:0] s;
        s = 8'(m_sum);
        return {s, 4'(m_cnt), logic'(m_cnt == DEPTH), m_ovf, glyph(s[7:4]), glyph(s[3:0])};
    endfunction

    function automatic void model_load(input int v);
        if (m_cnt < DEPTH) begin
            if (m_sum + v > 255) m_ovf = 1'b1;
            m_sum = (m_sum + v) % 256;
            m_cnt = m_cnt + 1;
        end
    endfunction

    function automatic void model_clear();
        m_sum = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endfunction

    task automatic do_press(input logic ld, input logic cl, input logic [7:0] v, input int hold);
        sw = v;
        key_load = !ld;
        key_clr = !cl;
        repeat (hold) @(posedge clk);
        #1;
        key_load = 1'b1;
        key_clr = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;
        if (cl) model_clear();
        else if (ld) model_load(int'(v));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h expected 00", sum); end
        n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        n_checks++; if ({done, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {done, ovf}); end
        n_checks++; if (hex !== 14'b1000000_1000000) begin n_fail++; $display("FAIL reset_hex: got %b expected %b", hex, 14'b1000000_1000000); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_release_cnt: got %0d expected 0", cnt); end
    endtask

`ifdef SUMMATOR_N_DEBOUNCE_EN
    task automatic test_glitch();
        sw = 8'h3C;
        key_load = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        key_load = 1'b1;
        repeat (DEB + 6) @(posedge clk);
        #1;
        n_checks++; if ({sum, cnt} !== {8'h00, 4'd0}) begin n_fail++; $display("FAIL glitch: got sum %h cnt %0d expected 00 0", sum, cnt); end
    endtask
`endif

    task automatic test_latency();
        int seen;
        sw = 8'h07;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        seen = 0;
        for (int k = 1; k <= LAT + 6 && seen == 0; k++) begin
            @(posedge clk);
            #1;
            if (cnt !== 4'd0) seen = k;
            if (k == 20) key_load = 1'b1;
        end
        key_load = 1'b1;
        model_load(7);
        n_checks++; if (seen != LAT) begin n_fail++; $display("FAIL load_latency: got edge %0d expected edge %0d", seen, LAT); end
        n_checks++; if (sum !== 8'h07) begin n_fail++; $display("FAIL latency_sum: got %h expected 07", sum); end
        repeat (LAT + 6) @(posedge clk);
        #1;
        n_checks++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL single_pulse_cnt: got %0d expected 1", cnt); end
    endtask

    task automatic test_full_run();
        do_press(1'b0, 1'b1, 8'h00, LAT + 2);
        do_press(1'b1, 1'b0, 8'h10, LAT + 2);
        do_press(1'b1, 1'b0, 8'h20, LAT + 2);
        do_press(1'b1, 1'b0, 8'h30, LAT + 2);
        do_press(1'b1, 1'b0, 8'h40, LAT + 2);
        n_checks++; if ({sum, cnt, done, ovf} !== {8'hA0, 4'd4, 1'b1, 1'b0}) begin n_fail++; $display("FAIL full_run: got sum %h cnt %0d done %b ovf %b expected A0 4 1 0", sum, cnt, done, ovf); end
        n_checks++; if (hex !== {7'b0001000, 7'b1000000}) begin n_fail++; $display("FAIL full_run_hex: got %b expected %b", hex, {7'b0001000, 7'b1000000}); end
        do_press(1'b1, 1'b0, 8'h55, LAT + 2);
        n_checks++; if ({sum, cnt, ovf} !== {8'hA0, 4'd4, 1'b0}) begin n_fail++; $display("FAIL full_ignore: got sum %h cnt %0d ovf %b expected A0 4 0", sum, cnt, ovf); end
        do_press(1'b1, 1'b1, 8'h99, LAT + 2);
        n_checks++; if ({sum, cnt, done} !== {8'h00, 4'd0, 1'b0}) begin n_fail++; $display("FAIL clear_wins: got sum %h cnt %0d done %b expected 00 0 0", sum, cnt, done); end
    endtask

    task automatic test_overflow();
        do_press(1'b1, 1'b0, 8'hF0, LAT + 2);
        do_press(1'b1, 1'b0, 8'h20, LAT + 2);
        n_checks++; if ({sum, cnt, ovf} !== {8'h10, 4'd2, 1'b1}) begin n_fail++; $display("FAIL overflow: got sum %h cnt %0d ovf %b expected 10 2 1", sum, cnt, ovf); end
        do_press(1'b1, 1'b0, 8'h01, LAT + 2);
        n_checks++; if ({sum, ovf} !== {8'h11, 1'b1}) begin n_fail++; $display("FAIL ovf_sticky: got sum %h ovf %b expected 11 1", sum, ovf); end
        do_press(1'b0, 1'b1, 8'h00, LAT + 2);
        n_checks++; if ({sum, cnt, ovf} !== {8'h00, 4'd0, 1'b0}) begin n_fail++; $display("FAIL overflow_clear: got sum %h cnt %0d ovf %b expected 00 0 0", sum, cnt, ovf); end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] v;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 5);
            v = 8'($urandom_range(0, 255));
            if (r == 0 || (m_cnt == DEPTH && r < 3)) do_press(1'b0, 1'b1, v, LAT + 2);
            else if (r == 5) do_press(1'b1, 1'b1, v, LAT + 2);
            else do_press(1'b1, 1'b0, v, LAT + 2);
            n_checks++;
            if ({sum, cnt, done, ovf, hex} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_op%0d: got %h expected %h", i, {sum, cnt, done, ovf, hex}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_press(1'b0, 1'b1, 8'h00, LAT + 2);
        do_press(1'b1, 1'b0, 8'h11, LAT + 2);
        do_press(1'b1, 1'b0, 8'h22, LAT + 2);
        n_checks++; if (cnt !== 4'd2) begin n_fail++; $display("FAIL mid_run_setup: got cnt %0d expected 2", cnt); end
        sw = 8'h33;
        key_load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (LAT + 8) @(posedge clk);
        #1;
        model_clear();
        n_checks++; if ({sum, cnt, done, ovf, hex} !== exp_vec()) begin n_fail++; $display("FAIL held_through_reset: got %h expected %h", {sum, cnt, done, ovf, hex}, exp_vec()); end
        key_load = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        #1;
        n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL release_after_reset: got cnt %0d expected 0", cnt); end
        do_press(1'b1, 1'b0, 8'h33, LAT + 2);
        n_checks++; if ({sum, cnt} !== {8'h33, 4'd1}) begin n_fail++; $display("FAIL repress_after_reset: got sum %h cnt %0d expected 33 1", sum, cnt); end
    endtask

    initial begin
        test_reset();
`ifdef SUMMATOR_N_DEBOUNCE_EN
        test_glitch();
`endif
        test_latency();
        test_full_run();
        test_overflow();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
